count_wrap_monitor: RTL
=======================

Name: count_wrap_monitor

Overview:
- Downstream consumer of the 3-bit ripple counter output.
- Ripple outputs settle bit-by-bit, so the block first resynchronises and stability-filters the count into the `clk` domain.
- It then checks that each accepted value is a +1 step modulo 2^WIDTH, and pulses and counts every 7->0 wrap.
- It raises a sticky error on any illegal step, for use by the status/debug logic.

Parameters:
- WIDTH, 3: width of the monitored count (range 0 to 2^WIDTH-1).
- SYNC_STAGES, 2: number of synchroniser flops on count_in (minimum 2).
- WRAP_CNT_W, 8: width of the wrap counter.

Ports:
- clk  in  1  system clock; all flops are on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low.
- count_in  in  WIDTH  raw ripple counter output (data_out); may glitch between values.
- enable  in  1  monitoring enable.
- err_clr  in  1  clears step_err (synchronous).
- count_q  out  WIDTH  last accepted (stable, synchronised) count value.
- valid  out  1  count_q holds a value accepted since the last entry to ACQUIRE.
- wrap_pulse  out  1  one-cycle pulse when an accepted step is max->0.
- wrap_count  out  WRAP_CNT_W  number of wraps; saturates at all-ones.
- step_err  out  1  sticky: an accepted step was not +1 mod 2^WIDTH.

Behaviour:
- Reset (rst=0, async):
  - sync chain, prev, count_q, wrap_count = 0.
  - valid, wrap_pulse, step_err = 0.
  - state = IDLE.
  - Reset mid-operation discards all progress; there is no partial state.
- Sync chain:
  - SYNC_STAGES flops, always running regardless of state.
  - sync = the last stage. prev <= sync every cycle.
  - stable = (sync == prev).
- Latency: a value first sampled at edge 1 and held steady appears on count_q after edge SYNC_STAGES+2 (edge 4 at the default). wrap_pulse and step_err update on that same edge.
- Glitch rejection: a value lasting one clk sample is never accepted, because stable requires two equal consecutive sync values.
- FSM, IDLE:
  - valid=0; count_q and wrap_count are held.
  - enable=1 -> ACQUIRE.
- FSM, ACQUIRE:
  - On the first cycle with stable=1: count_q <= sync, valid <= 1, go to TRACK.
  - No step check is made on this load.
  - enable=0 -> IDLE.
- FSM, TRACK:
  - Acceptance occurs when stable=1 and sync != count_q. Then:
    - count_q <= sync.
    - If sync == count_q+1 mod 2^WIDTH, the step is legal.
    - If the legal step is count_q == 2^WIDTH-1 to sync == 0: wrap_pulse <= 1 for exactly one cycle, and wrap_count <= wrap_count+1, saturating at 2^WRAP_CNT_W-1.
    - Otherwise step_err <= 1. count_q still resynchronises to the new value, and the next step is checked from it.
  - stable=1 with sync == count_q: no action.
  - enable=0 -> IDLE. valid drops on the same edge; any acceptance on that edge is ignored.
- Re-enable:
  - Always passes through ACQUIRE, so no false step_err is raised after a pause.
  - wrap_count is not cleared.
- wrap_pulse is 0 in every cycle not described above.
- step_err:
  - Sticky until err_clr=1.
  - If err_clr and a new error occur on the same edge, set wins (step_err stays 1).
- Arithmetic:
  - The +1 comparison is WIDTH-bit modulo.
  - wrap_count never rolls over.

Test Plan:
- Reset release, enable=1, count_in stepping 0..7,0,1, each value held 3+ clk cycles:
  - count_q follows each value 3 edges after it is first sampled.
  - valid=1 from the first acceptance.
  - A single wrap_pulse on 7->0; wrap_count=1; step_err=0.
- Glitch: count_in 3 -> 2 for one cycle -> 4, simulating a ripple transition:
  - 2 is never accepted.
  - count_q goes 3->4; no step_err.
- Skip: count_in 2 -> 5, held:
  - count_q=5; step_err=1 and stays 1.
  - Then err_clr=1 for one cycle -> step_err=0.
  - Subsequent 5->6 raises no error.
- Pause: enable=0 with count_q=6; count_in moves to 1; enable=1:
  - valid=0 while paused.
  - After re-enable, count_q=1, valid=1, step_err=0, wrap_count unchanged.
- Saturation, with WRAP_CNT_W=2: run 5 full cycles 0..7:
  - wrap_count sequence is 1,2,3,3,3.
  - wrap_pulse is still seen 5 times.
- Async reset asserted mid-count (count_q=4, wrap_count=2):
  - All outputs are 0 immediately, without a clk edge.
  - After release the block restarts in IDLE and re-acquires the count.

Source files
------------

// File: rtl/count_wrap_monitor.sv
// Resynchronises a ripple-counter value into the clk domain, filters glitches,
// checks for +1 steps, and counts and flags max->0 wraps and illegal steps.
module count_wrap_monitor #(
    parameter int unsigned WIDTH       = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WRAP_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      count_in,
    input  logic                  enable,
    input  logic                  err_clr,
    output logic [WIDTH-1:0]      count_q,
    output logic                  valid,
    output logic                  wrap_pulse,
    output logic [WRAP_CNT_W-1:0] wrap_count,
    output logic                  step_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain;
    logic [WIDTH-1:0]                  sync;
    logic [WIDTH-1:0]                  prev;
    logic                              stable;
    logic [WIDTH-1:0]                  count_inc;

    logic [WIDTH-1:0]      count_nxt;
    logic                  valid_nxt;
    logic                  pulse_nxt;
    logic [WRAP_CNT_W-1:0] wrap_nxt;
    logic                  err_set;
    logic                  err_nxt;

    // Synchroniser and stability history run in every state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_chain <= '0;
            prev       <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], count_in};
            prev       <= sync;
        end
    end

    assign sync      = sync_chain[SYNC_STAGES-1];
    assign stable    = (sync == prev);
    assign count_inc = count_q + WIDTH'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count_q    <= '0;
            valid      <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_count <= '0;
            step_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            count_q    <= count_nxt;
            valid      <= valid_nxt;
            wrap_pulse <= pulse_nxt;
            wrap_count <= wrap_nxt;
            step_err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count_q;
        valid_nxt = valid;
        pulse_nxt = 1'b0;
        wrap_nxt  = wrap_count;
        err_set   = 1'b0;

        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                if (enable) begin
                    state_nxt = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (!enable) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                end else if (stable) begin
                    count_nxt = sync;
                    valid_nxt = 1'b1;
                    state_nxt = TRACK;
                end
            end
            TRACK: begin
                if (!enable) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                end else if (stable && (sync != count_q)) begin
                    count_nxt = sync;
                    if (sync == count_inc) begin
                        // Legal step out of the maximum value is the wrap.
                        if (count_q == '1) begin
                            pulse_nxt = 1'b1;
                            if (wrap_count != '1) begin
                                wrap_nxt = wrap_count + WRAP_CNT_W'(1);
                            end
                        end
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase

        if (err_set) begin
            err_nxt = 1'b1;
        end else if (err_clr) begin
            err_nxt = 1'b0;
        end else begin
            err_nxt = step_err;
        end
    end

endmodule
